// File: rtl/uart_pkg.sv
// Shared constants, state encoding and parity helper for the UART transmit path.
package uart_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned DATA_BITS  = 8;

  localparam bit PARITY_MODE_EVEN = 1'b0;
  localparam bit PARITY_MODE_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Bit that makes data plus parity carry an even (odd=0) or odd (odd=1) count of ones.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Synchronous TX FIFO with registered empty/full flags, word count and sticky overflow.
module uart_tx_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic [AW:0]      next_count;

  // A write against a full FIFO is rejected even if a pop frees a slot in the same cycle.
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    next_count = count;
    if (push && !pop)
      next_count = count + 1'b1;
    else if (pop && !push)
      next_count = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full)
        overflow <= 1'b1;
      count <= next_count;
      empty <= (next_count == '0);
      full  <= (next_count == (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: FIFO-fed 8-bit frames with start, parity and stop bits, one bit per baud_clk.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_T = 16,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                          baud_clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          send_order,
  input  logic                          tx_enable,
  output logic                          tx,
  output logic                          TxFE,
  output logic                          TxFF,
  output logic                          Tx_busy,
  output logic                          Tx_done,
  output logic                          Tx_overflow,
  output logic [$clog2(FIFO_DEPTH_T):0] fifo_count
);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] head;
  logic                 par_bit;
  logic [2:0]           bit_cnt;
  logic                 pop;

  // A new frame may only begin from IDLE or from the last STOP cycle of the previous one.
  assign pop = !TxFE && tx_enable && (state == ST_IDLE || state == ST_STOP);

  uart_tx_sync_fifo #(
    .DEPTH(FIFO_DEPTH_T),
    .WIDTH(DATA_BITS)
  ) u_fifo (
    .clk      (baud_clk),
    .rst      (rst),
    .wr_en    (send_order),
    .wr_data  (data_in),
    .rd_en    (pop),
    .rd_data  (head),
    .empty    (TxFE),
    .full     (TxFF),
    .overflow (Tx_overflow),
    .count    (fifo_count)
  );

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      shreg   <= '0;
      par_bit <= 1'b0;
      bit_cnt <= '0;
      Tx_busy <= 1'b0;
      Tx_done <= 1'b0;
    end else begin
      Tx_done <= 1'b0;
      case (state)
        ST_IDLE, ST_STOP: begin
          if (pop) begin
            shreg   <= head;
            par_bit <= parity_of(head, PARITY_ODD);
            state   <= ST_START;
            tx      <= 1'b0;
            Tx_busy <= 1'b1;
          end else begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            Tx_busy <= 1'b0;
          end
        end
        ST_START: begin
          state   <= ST_DATA;
          tx      <= shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= '0;
        end
        ST_DATA: begin
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            state <= ST_PARITY;
            tx    <= par_bit;
          end else begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
          end
          bit_cnt <= bit_cnt + 3'd1;
        end
        ST_PARITY: begin
          state   <= ST_STOP;
          tx      <= 1'b1;
          Tx_done <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          tx      <= 1'b1;
          Tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: frame vectors, FIFO fill/overflow, back-to-back and reset cases.
module tb_uart_tx_serializer;

  logic       baud_clk;
  logic       rst;
  logic [7:0] data_in;
  logic       send_order;
  logic       tx_enable;

  logic       tx, TxFE, TxFF, Tx_busy, Tx_done, Tx_overflow;
  logic [4:0] fifo_count;
  logic       tx_o, TxFE_o, TxFF_o, Tx_busy_o, Tx_done_o, Tx_overflow_o;
  logic [4:0] fifo_count_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  sb[$];

  typedef struct {
    logic [7:0] data;
    logic       par_even;
  } vec_t;

  vec_t vecs[7];

  uart_tx_serializer #(.FIFO_DEPTH_T(16), .PARITY_ODD(1'b0)) dut (
    .baud_clk(baud_clk), .rst(rst), .data_in(data_in), .send_order(send_order),
    .tx_enable(tx_enable), .tx(tx), .TxFE(TxFE), .TxFF(TxFF), .Tx_busy(Tx_busy),
    .Tx_done(Tx_done), .Tx_overflow(Tx_overflow), .fifo_count(fifo_count)
  );

  uart_tx_serializer #(.FIFO_DEPTH_T(16), .PARITY_ODD(1'b1)) dut_odd (
    .baud_clk(baud_clk), .rst(rst), .data_in(data_in), .send_order(send_order),
    .tx_enable(tx_enable), .tx(tx_o), .TxFE(TxFE_o), .TxFF(TxFF_o), .Tx_busy(Tx_busy_o),
    .Tx_done(Tx_done_o), .Tx_overflow(Tx_overflow_o), .fifo_count(fifo_count_o)
  );

  initial baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic even_par(input logic [7:0] d);
    int unsigned ones = 0;
    for (int unsigned b = 0; b < 8; b++) ones += d[b];
    return (ones % 2) == 1;
  endfunction

  task automatic write_byte(input logic [7:0] d, input bit accept);
    send_order = 1'b1;
    data_in    = d;
    if (accept) sb.push_back(d);
    tick();
    send_order = 1'b0;
  endtask

  // Checks frame bits first_bit..10 of the next scoreboard word, one tick per bit.
  task automatic check_frame(input int first_bit, input logic par_even);
    logic [7:0]  d;
    logic [10:0] fe, fo;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_underflow: got empty queue expected a word at %0t", $time);
      return;
    end
    d  = sb.pop_front();
    fe = {1'b1, par_even, d, 1'b0};
    fo = {1'b1, ~par_even, d, 1'b0};
    for (int i = first_bit; i < 11; i++) begin
      tick();
      check($sformatf("tx_%02h_bit%0d", d, i), tx, fe[i]);
      check($sformatf("tx_odd_%02h_bit%0d", d, i), tx_o, fo[i]);
      check($sformatf("busy_%02h_bit%0d", d, i), Tx_busy, 1'b1);
      check($sformatf("done_%02h_bit%0d", d, i), Tx_done, (i == 10));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    rst = 1'b0; data_in = '0; send_order = 1'b0; tx_enable = 1'b1;
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h01, 1'b1};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'h7F, 1'b1};
    vecs[6] = '{8'h3C, 1'b0};

    do_reset();
    check("rst_tx", tx, 1'b1);
    check("rst_TxFE", TxFE, 1'b1);
    check("rst_TxFF", TxFF, 1'b0);
    check("rst_busy", Tx_busy, 1'b0);
    check("rst_done", Tx_done, 1'b0);
    check("rst_ovf", Tx_overflow, 1'b0);
    check("rst_count", fifo_count, 0);

    // single frames from an idle unit
    for (int v = 0; v < 7; v++) begin
      write_byte(vecs[v].data, 1'b1);
      check("wr_count", fifo_count, 1);
      check("wr_TxFE", TxFE, 1'b0);
      check("wr_tx_idle", tx, 1'b1);
      check("wr_busy", Tx_busy, 1'b0);
      check_frame(0, vecs[v].par_even);
      tick();
      check("post_busy", Tx_busy, 1'b0);
      check("post_tx", tx, 1'b1);
      check("post_done", Tx_done, 1'b0);
      check("post_TxFE", TxFE, 1'b1);
    end

    // fill past full with transmission disabled
    tx_enable = 1'b0;
    for (int k = 0; k < 17; k++) begin
      write_byte(8'(8'h10 + k * 7), k < 16);
      check("fill_tx", tx, 1'b1);
    end
    check("fill_count", fifo_count, 16);
    check("fill_TxFF", TxFF, 1'b1);
    check("fill_ovf", Tx_overflow, 1'b1);
    tick();
    check("fill_hold_tx", tx, 1'b1);
    check("fill_hold_busy", Tx_busy, 1'b0);
    tx_enable = 1'b1;
    check_frame(0, even_par(sb[0]));
    check("drain_count15", fifo_count, 15);
    for (int k = 1; k < 16; k++) check_frame(0, even_par(sb[0]));
    check("drain_count0", fifo_count, 0);
    check("drain_TxFE", TxFE, 1'b1);
    check("drain_ovf_sticky", Tx_overflow, 1'b1);
    tick();
    check("drain_idle_busy", Tx_busy, 1'b0);

    // write while full coincides with the pop that starts a frame
    do_reset();
    check("ovf_cleared", Tx_overflow, 1'b0);
    tx_enable = 1'b0;
    for (int k = 0; k < 16; k++) write_byte(8'(8'hC0 + k), 1'b1);
    check("full2_TxFF", TxFF, 1'b1);
    tx_enable = 1'b1;
    write_byte(8'hEE, 1'b0);
    check("popwr_count", fifo_count, 15);
    check("popwr_ovf", Tx_overflow, 1'b1);
    check("popwr_TxFF", TxFF, 1'b0);
    check("popwr_start", tx, 1'b0);
    check_frame(1, even_par(sb[0]));
    for (int k = 1; k < 16; k++) check_frame(0, even_par(sb[0]));
    check("popwr_empty", TxFE, 1'b1);

    // back-to-back: second word written during the first start bit
    do_reset();
    write_byte(8'h96, 1'b1);
    write_byte(8'h4B, 1'b1);
    check("b2b_start", tx, 1'b0);
    check("b2b_count", fifo_count, 1);
    check_frame(1, even_par(8'h96));
    check_frame(0, even_par(8'h4B));
    tick();
    check("b2b_idle", Tx_busy, 1'b0);

    // tx_enable dropped mid-frame: frame completes, next one waits
    write_byte(8'h21, 1'b1);
    write_byte(8'h22, 1'b1);
    tick(); tick();
    tx_enable = 1'b0;
    check_frame(3, even_par(8'h21));
    tick();
    check("dis_tx", tx, 1'b1);
    check("dis_busy", Tx_busy, 1'b0);
    check("dis_count", fifo_count, 1);
    tx_enable = 1'b1;
    check_frame(0, even_par(8'h22));
    tick();

    // reset during data bit 4 with another word queued
    write_byte(8'h3C, 1'b1);
    write_byte(8'h99, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    check("pre_rst_bit4", tx, 1'b1);
    do_reset();
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", Tx_busy, 1'b0);
    check("midrst_count", fifo_count, 0);
    check("midrst_TxFE", TxFE, 1'b1);
    tick();
    check("midrst_tx2", tx, 1'b1);
    write_byte(8'h5A, 1'b1);
    check_frame(0, 1'b0);
    tick();
    check("final_idle", Tx_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH_T, default 16, TX FIFO depth in words; must be a power of two and at least 2.
REQ-002 SHALL have parameter PARITY_ODD, default 0, parity mode: 0 = even, 1 = odd.
REQ-003 SHALL have port baud_clk  input  1  the single clock; one UART bit per cycle.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port data_in  input  8  parallel byte to transmit.
REQ-006 SHALL have port send_order  input  1  write strobe; data_in is pushed when accepted.
REQ-007 SHALL have port tx_enable  input  1  permits starting new frames.
REQ-008 SHALL have port tx  output  1  serial line; idle high.
REQ-009 SHALL have port TxFE  output  1  FIFO empty.
REQ-010 SHALL have port TxFF  output  1  FIFO full.
REQ-011 SHALL have port Tx_busy  output  1  a frame is in progress (state != IDLE).
REQ-012 SHALL have port Tx_done  output  1  one-cycle pulse in the final STOP cycle of each frame.
REQ-013 SHALL have port Tx_overflow  output  1  sticky; a write was rejected.
REQ-014 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH_T)+1  number of words stored.

Function
REQ-015 SHALL transmit each frame as 11 bits: start 0, data[0]..data[7] LSB first, parity, stop 1.
REQ-016 SHALL compute the parity bit so that data plus parity has an even count of ones when PARITY_ODD=0, and an odd count when PARITY_ODD=1.
REQ-017 SHALL accept a write when send_order=1 and TxFF=0 as sampled at the edge; the write pointer increments modulo FIFO_DEPTH_T.
REQ-018 SHALL ignore a write when send_order=1 and TxFF=1, including when a pop occurs in the same cycle, and SHALL set Tx_overflow.
REQ-019 SHALL update fifo_count by +1 on a push only, -1 on a pop only, and 0 on a simultaneous push and pop.
REQ-020 SHALL drive TxFE=(fifo_count==0) and TxFF=(fifo_count==FIFO_DEPTH_T), both registered and consistent with fifo_count every cycle.
REQ-021 SHALL implement a state machine with states IDLE, START, DATA, PARITY, STOP.
REQ-022 In IDLE, when TxFE=0 and tx_enable=1, SHALL pop the head word into the shift register and enter START; otherwise SHALL remain in IDLE.
REQ-023 SHALL move START->DATA after 1 cycle, DATA->PARITY after 8 cycles (3-bit bit counter wraps 7->0), and PARITY->STOP after 1 cycle.
REQ-024 In STOP, when TxFE=0 and tx_enable=1, SHALL pop and enter START directly, with no idle cycle between frames; otherwise SHALL enter IDLE.
REQ-025 SHALL drive tx from a flop: 1 in IDLE and STOP, 0 in START, the current data bit in DATA, the parity bit in PARITY.
REQ-026 SHALL, for a write accepted at edge N into an idle, empty unit with tx_enable=1, drive the start bit from edge N+1.
REQ-027 SHALL, when tx_enable is deasserted mid-frame, complete the current frame and start no new frame.
REQ-028 SHALL raise Tx_busy from edge N+1 and hold it until the edge that enters IDLE.

Reset
REQ-029 On rst=1 at a baud_clk edge SHALL set: state IDLE, tx=1, pointers=0, fifo_count=0, TxFE=1, TxFF=0, Tx_busy=0, Tx_done=0, Tx_overflow=0, shift register and bit counter=0.
REQ-030 A reset mid-frame SHALL abandon the frame and discard all FIFO contents; tx SHALL be high from the reset edge onward.
REQ-031 Tx_overflow SHALL clear only on reset.

Structure
REQ-032 A shared package uart_pkg SHALL hold the state encoding, FRAME_BITS=11, DATA_BITS=8, and the parity-mode constants.
REQ-033 The FIFO storage, pointers, count and flags SHALL form one sub-module, uart_tx_sync_fifo; the state machine, shift register and parity logic SHALL stay in the top level.

Verification
REQ-034 Idle unit, tx_enable=1, write 0xA5 with PARITY_ODD=0 -> tx = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles starting one cycle after the write; Tx_done pulses once; then IDLE.
REQ-035 Write 0x01 with PARITY_ODD=0 -> parity bit 1; repeat with PARITY_ODD=1 -> parity bit 0.
REQ-036 tx_enable=0, write 17 words -> fifo_count=16, TxFF=1, Tx_overflow=1, tx held high; then set tx_enable=1 -> 16 frames in 176 cycles, words in write order, TxFE=1 at the end.
REQ-037 Two words written back-to-back -> 22 consecutive frame cycles with no idle cycle between the first stop bit and the second start bit.
REQ-038 Reset asserted during data bit 4 -> from the reset edge tx=1, Tx_busy=0, fifo_count=0, TxFE=1; the next write transmits normally.
REQ-039 FIFO full and a frame popping in the same cycle as send_order=1 -> write rejected, fifo_count goes 16->15, Tx_overflow=1.
